// File: rtl/mcif_rd_sched4.sv
// mcif_rd_sched4: 4-client round-robin read scheduler with in-order response routing (optional MCIF_RD_PRIO_EN gives client 0 fixed priority)
module mcif_rd_sched4 #(
   parameter int ADDR_W   = 32,
   parameter int LEN_W    = 8,
   parameter int DATA_W   = 64,
   parameter int ID_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            cl_req_valid,
   output logic [3:0]            cl_req_ready,
   input  logic [4*ADDR_W-1:0]   cl_req_addr,
   input  logic [4*LEN_W-1:0]    cl_req_len,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic [ADDR_W-1:0]     mem_cmd_addr,
   output logic [LEN_W-1:0]      mem_cmd_len,
   input  logic                  mem_rsp_valid,
   input  logic                  mem_rsp_last,
   input  logic [DATA_W-1:0]     mem_rsp_data,
   output logic                  mem_rsp_ready,
   output logic [3:0]            cl_rsp_valid,
   input  logic [3:0]            cl_rsp_ready,
   output logic [DATA_W-1:0]     cl_rsp_data,
   output logic                  cl_rsp_last,
   output logic                  busy
);
   localparam int PW = $clog2(ID_DEPTH);
   logic              cmd_valid_q, cmd_valid_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
   logic [1:0]        rr_q, rr_d;
   logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [1:0]        ids_q [ID_DEPTH];
   logic [3:0]        cand;
   logic [1:0]        win, idx, head;
   logic              found, capture, pop, empty, full;
   // Arbitration: first requester after rr_q, client 0 overriding when priority is enabled
   always_comb begin
`ifdef MCIF_RD_PRIO_EN
      cand = {cl_req_valid[3:1], 1'b0};
`else
      cand = cl_req_valid;
`endif
      found = 1'b0;
      win   = rr_q;
      idx   = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = rr_q + 2'(k);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
`ifdef MCIF_RD_PRIO_EN
      if (cl_req_valid[0]) begin
         found = 1'b1;
         win   = 2'd0;
      end
`endif
   end
   assign empty         = cnt_q == '0;
   assign full          = cnt_q[PW];
   assign capture       = (!cmd_valid_q || mem_cmd_ready) && !full && found;
   assign cl_req_ready  = capture ? 4'b0001 << win : 4'b0000;
   assign head          = ids_q[rd_q];
   assign cl_rsp_valid  = (mem_rsp_valid && !empty) ? 4'b0001 << head : 4'b0000;
   assign mem_rsp_ready = !empty && cl_rsp_ready[head];
   assign pop           = mem_rsp_valid && mem_rsp_ready && mem_rsp_last;
   assign cl_rsp_data   = mem_rsp_data;
   assign cl_rsp_last   = mem_rsp_last;
   assign mem_cmd_valid = cmd_valid_q;
   assign mem_cmd_addr  = cmd_addr_q;
   assign mem_cmd_len   = cmd_len_q;
   assign busy          = cmd_valid_q || !empty;
   // Next state: command register holds under backpressure, FIFO pointers advance on push/pop
   always_comb begin
      cmd_valid_d = capture || (cmd_valid_q && !mem_cmd_ready);
      cmd_addr_d  = capture ? cl_req_addr[win*ADDR_W +: ADDR_W] : cmd_addr_q;
      cmd_len_d   = capture ? cl_req_len[win*LEN_W +: LEN_W] : cmd_len_q;
`ifdef MCIF_RD_PRIO_EN
      rr_d        = (capture && win != 2'd0) ? win : rr_q;
`else
      rr_d        = capture ? win : rr_q;
`endif
      wr_d        = wr_q + PW'(capture);
      rd_d        = rd_q + PW'(pop);
      cnt_d       = cnt_q + (PW+1)'(capture) - (PW+1)'(pop);
   end
   // State registers; rr_q resets to 3 so client 0 is searched first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
         rr_q        <= 2'd3;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
         rr_q        <= rr_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
      end
   end
   // ID storage needs no reset: entries are only read while counted valid
   always_ff @(posedge clk) begin
      if (capture) ids_q[wr_q] <= win;
   end
endmodule

// File: tb/tb_mcif_rd_sched4.sv
// tb_mcif_rd_sched4: directed self-checking bench for mcif_rd_sched4
module tb_mcif_rd_sched4;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    cl_req_valid, cl_req_ready;
   logic [127:0]  cl_req_addr;
   logic [31:0]   cl_req_len;
   logic          mem_cmd_valid, mem_cmd_ready;
   logic [31:0]   mem_cmd_addr;
   logic [7:0]    mem_cmd_len;
   logic          mem_rsp_valid, mem_rsp_last, mem_rsp_ready;
   logic [63:0]   mem_rsp_data, cl_rsp_data;
   logic [3:0]    cl_rsp_valid, cl_rsp_ready;
   logic          cl_rsp_last, busy;
   int            checks = 0;
   int            fails = 0;

   mcif_rd_sched4 dut (
      .clk(clk), .rst_n(rst_n),
      .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready),
      .cl_req_addr(cl_req_addr), .cl_req_len(cl_req_len),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_last(mem_rsp_last),
      .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
      .cl_rsp_valid(cl_rsp_valid), .cl_rsp_ready(cl_rsp_ready),
      .cl_rsp_data(cl_rsp_data), .cl_rsp_last(cl_rsp_last), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      cl_req_valid  = '0;
      cl_req_addr   = '0;
      cl_req_len    = '0;
      mem_cmd_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_last  = 1'b0;
      mem_rsp_data  = '0;
      cl_rsp_ready  = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l);
      cl_req_addr[i*32 +: 32] = a;
      cl_req_len[i*8 +: 8]    = l;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      mem_rsp_valid = 1'b1;
      cl_rsp_ready  = 4'hf;
      #1;
      checks++; if (mem_cmd_valid !== 1'b0) begin fails++; $display("FAIL reset_cmd_valid: got %b want 0", mem_cmd_valid); end
      checks++; if (mem_cmd_addr !== 32'h0) begin fails++; $display("FAIL reset_cmd_addr: got %h want 0", mem_cmd_addr); end
      checks++; if (mem_cmd_len !== 8'h0) begin fails++; $display("FAIL reset_cmd_len: got %h want 0", mem_cmd_len); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (mem_rsp_ready !== 1'b0) begin fails++; $display("FAIL reset_rsp_ready: got %b want 0", mem_rsp_ready); end
      checks++; if (cl_rsp_valid !== 4'h0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0000", cl_rsp_valid); end
      do_reset();
   endtask

   task automatic test_round_robin();
      int w;
      do_reset();
      mem_cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 32'h1000 * (i + 1), 8'(i + 1));
      cl_req_valid = 4'hf;
      #1;
      for (int n = 0; n < 5; n++) begin
         w = n % 4;
         checks++; if (cl_req_ready !== 4'(1 << w)) begin fails++; $display("FAIL rr_ready[%0d]: got %b want %b", n, cl_req_ready, 4'(1 << w)); end
         tick();
         checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h1000 * (w + 1) || mem_cmd_len !== 8'(w + 1))
            begin fails++; $display("FAIL rr_cmd[%0d]: got v=%b a=%h l=%h want v=1 a=%h l=%h", n, mem_cmd_valid, mem_cmd_addr, mem_cmd_len, 32'h1000 * (w + 1), 8'(w + 1)); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      set_req(2, 32'h0000_a200, 8'd5);
      set_req(0, 32'h0000_b000, 8'd3);
      cl_req_valid = 4'b0100;
      #1;
      checks++; if (cl_req_ready !== 4'b0100) begin fails++; $display("FAIL stall_first_ready: got %b want 0100", cl_req_ready); end
      tick();
      cl_req_valid = 4'b0001;
      #1;
      for (int n = 0; n < 5; n++) begin
         checks++; if (cl_req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready[%0d]: got %b want 0000", n, cl_req_ready); end
         tick();
         checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h0000_a200 || mem_cmd_len !== 8'd5)
            begin fails++; $display("FAIL stall_hold[%0d]: got v=%b a=%h l=%h want v=1 a=0000a200 l=05", n, mem_cmd_valid, mem_cmd_addr, mem_cmd_len); end
      end
      mem_cmd_ready = 1'b1;
      #1;
      checks++; if (cl_req_ready !== 4'b0001) begin fails++; $display("FAIL stall_b2b_ready: got %b want 0001", cl_req_ready); end
      tick();
      cl_req_valid = 4'b0000;
      checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h0000_b000) begin fails++; $display("FAIL stall_b2b_cmd: got v=%b a=%h want v=1 a=0000b000", mem_cmd_valid, mem_cmd_addr); end
      tick();
      checks++; if (mem_cmd_valid !== 1'b0) begin fails++; $display("FAIL stall_drain: got %b want 0", mem_cmd_valid); end
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL stall_busy: got %b want 1", busy); end
   endtask

   task automatic test_fifo_full();
      do_reset();
      mem_cmd_ready = 1'b1;
      set_req(1, 32'h0000_c100, 8'd0);
      cl_req_valid = 4'b0010;
      #1;
      for (int n = 0; n < 8; n++) begin
         checks++; if (cl_req_ready !== 4'b0010) begin fails++; $display("FAIL full_fill[%0d]: got %b want 0010", n, cl_req_ready); end
         tick();
      end
      checks++; if (cl_req_ready !== 4'b0000) begin fails++; $display("FAIL full_block: got %b want 0000", cl_req_ready); end
      mem_rsp_valid = 1'b1;
      mem_rsp_last  = 1'b1;
      cl_rsp_ready  = 4'b0010;
      #1;
      checks++; if (cl_req_ready !== 4'b0000) begin fails++; $display("FAIL full_pop_same_cycle: got %b want 0000", cl_req_ready); end
      checks++; if (mem_rsp_ready !== 1'b1) begin fails++; $display("FAIL full_rsp_ready: got %b want 1", mem_rsp_ready); end
      checks++; if (cl_rsp_valid !== 4'b0010) begin fails++; $display("FAIL full_rsp_valid: got %b want 0010", cl_rsp_valid); end
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checks++; if (cl_req_ready !== 4'b0010) begin fails++; $display("FAIL full_after_pop: got %b want 0010", cl_req_ready); end
      checks++; if (mem_cmd_valid !== 1'b0) begin fails++; $display("FAIL full_idle_cmd: got %b want 0", mem_cmd_valid); end
      tick();
      cl_req_valid = 4'b0000;
      checks++; if (mem_cmd_valid !== 1'b1 || mem_cmd_addr !== 32'h0000_c100) begin fails++; $display("FAIL full_ninth_cmd: got v=%b a=%h want v=1 a=0000c100", mem_cmd_valid, mem_cmd_addr); end
   endtask

   task automatic test_rsp_routing();
      do_reset();
      mem_cmd_ready = 1'b1;
      set_req(1, 32'h0000_1100, 8'd1);
      set_req(3, 32'h0000_3300, 8'd0);
      cl_req_valid = 4'b0010;
      #1;
      checks++; if (cl_req_ready !== 4'b0010) begin fails++; $display("FAIL rsp_issue1: got %b want 0010", cl_req_ready); end
      tick();
      cl_req_valid = 4'b1000;
      #1;
      checks++; if (cl_req_ready !== 4'b1000) begin fails++; $display("FAIL rsp_issue3: got %b want 1000", cl_req_ready); end
      tick();
      cl_req_valid = 4'b0000;
      checks++; if (mem_cmd_addr !== 32'h0000_3300 || mem_cmd_len !== 8'd0) begin fails++; $display("FAIL rsp_cmd3: got a=%h l=%h want a=00003300 l=00", mem_cmd_addr, mem_cmd_len); end
      mem_rsp_valid = 1'b1;
      mem_rsp_last  = 1'b0;
      mem_rsp_data  = 64'hd1d1_0000_0000_0001;
      cl_rsp_ready  = 4'b1101;
      #1;
      for (int n = 0; n < 2; n++) begin
         checks++; if (cl_rsp_valid !== 4'b0010 || mem_rsp_ready !== 1'b0)
            begin fails++; $display("FAIL rsp_stall[%0d]: got valid=%b ready=%b want valid=0010 ready=0", n, cl_rsp_valid, mem_rsp_ready); end
         tick();
      end
      cl_rsp_ready = 4'b0010;
      #1;
      checks++; if (mem_rsp_ready !== 1'b1 || cl_rsp_data !== 64'hd1d1_0000_0000_0001)
         begin fails++; $display("FAIL rsp_beat1: got ready=%b data=%h want ready=1 data=d1d1000000000001", mem_rsp_ready, cl_rsp_data); end
      tick();
      mem_rsp_last = 1'b1;
      mem_rsp_data = 64'hd2d2_0000_0000_0002;
      #1;
      checks++; if (cl_rsp_valid !== 4'b0010 || mem_rsp_ready !== 1'b1 || cl_rsp_last !== 1'b1)
         begin fails++; $display("FAIL rsp_beat2: got valid=%b ready=%b last=%b want 0010 1 1", cl_rsp_valid, mem_rsp_ready, cl_rsp_last); end
      tick();
      mem_rsp_data = 64'hd3d3_0000_0000_0003;
      cl_rsp_ready = 4'b1000;
      #1;
      checks++; if (cl_rsp_valid !== 4'b1000 || mem_rsp_ready !== 1'b1)
         begin fails++; $display("FAIL rsp_beat3: got valid=%b ready=%b want 1000 1", cl_rsp_valid, mem_rsp_ready); end
      tick();
      mem_rsp_valid = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rsp_idle_busy: got %b want 0", busy); end
      mem_rsp_valid = 1'b1;
      #1;
      checks++; if (cl_rsp_valid !== 4'b0000 || mem_rsp_ready !== 1'b0)
         begin fails++; $display("FAIL rsp_empty_stall: got valid=%b ready=%b want 0000 0", cl_rsp_valid, mem_rsp_ready); end
      mem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_cmd_ready = 1'b1;
      for (int i = 0; i < 3; i++) set_req(i, 32'h0000_4000 + 32'(i), 8'd7);
      cl_req_valid = 4'b0111;
      repeat (3) tick();
      cl_req_valid  = 4'b0000;
      mem_cmd_ready = 1'b0;
      tick();
      checks++; if (mem_cmd_valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL mid_pending: got v=%b busy=%b want 1 1", mem_cmd_valid, busy); end
      mem_rsp_valid = 1'b1;
      cl_rsp_ready  = 4'hf;
      #1;
      checks++; if (cl_rsp_valid !== 4'b0001 || mem_rsp_ready !== 1'b1) begin fails++; $display("FAIL mid_head: got valid=%b ready=%b want 0001 1", cl_rsp_valid, mem_rsp_ready); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (mem_cmd_valid !== 1'b0 || mem_cmd_addr !== 32'h0 || mem_cmd_len !== 8'h0)
         begin fails++; $display("FAIL mid_cmd: got v=%b a=%h l=%h want 0 0 0", mem_cmd_valid, mem_cmd_addr, mem_cmd_len); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
      checks++; if (cl_rsp_valid !== 4'b0000 || mem_rsp_ready !== 1'b0) begin fails++; $display("FAIL mid_rsp: got valid=%b ready=%b want 0000 0", cl_rsp_valid, mem_rsp_ready); end
      checks++; if (cl_req_ready !== 4'b0000) begin fails++; $display("FAIL mid_req_ready: got %b want 0000", cl_req_ready); end
      do_reset();
   endtask

`ifdef MCIF_RD_PRIO_EN
   task automatic test_prio();
      do_reset();
      mem_cmd_ready = 1'b1;
      set_req(0, 32'h0000_0a00, 8'd0);
      set_req(1, 32'h0000_1a00, 8'd0);
      cl_req_valid = 4'b0011;
      #1;
      for (int n = 0; n < 3; n++) begin
         checks++; if (cl_req_ready !== 4'b0001) begin fails++; $display("FAIL prio_c0[%0d]: got %b want 0001", n, cl_req_ready); end
         tick();
      end
      cl_req_valid = 4'b0010;
      #1;
      checks++; if (cl_req_ready !== 4'b0010) begin fails++; $display("FAIL prio_c1: got %b want 0010", cl_req_ready); end
      tick();
      cl_req_valid = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_round_robin();
      test_stall();
      test_fifo_full();
      test_rsp_routing();
      test_reset_mid();
`ifdef MCIF_RD_PRIO_EN
      test_prio();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
